// File: rtl/math_booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package math_booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_t;

  // Number of Booth groups needed for an N-bit operand extended to N+1 bits.
  function automatic int unsigned booth_groups(input int unsigned n);
    return (n + 2) / 2;
  endfunction

  function automatic booth_sel_t booth_decode(input logic [2:0] grp);
    booth_sel_t sel;
    case (grp)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/math_multiplier_booth_radix_4_seq_if.sv
// Request/response bundle for the sequential Booth multiplier.
interface math_multiplier_booth_radix_4_seq_if #(
  parameter int unsigned N = 8
);
  logic             i_valid;
  logic             o_ready;
  logic             i_signed;
  logic [N-1:0]     i_multiplier;
  logic [N-1:0]     i_multiplicand;
  logic             o_valid;
  logic             i_ready;
  logic [2*N-1:0]   o_product;
  logic             o_busy;

  modport slave (
    input  i_valid, i_signed, i_multiplier, i_multiplicand, i_ready,
    output o_ready, o_valid, o_product, o_busy
  );

  modport master (
    output i_valid, i_signed, i_multiplier, i_multiplicand, i_ready,
    input  o_ready, o_valid, o_product, o_busy
  );
endinterface

// File: rtl/math_booth_r4_pp_gen.sv
// Radix-4 Booth partial-product generator for one 3-bit group.
module math_booth_r4_pp_gen
  import math_booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [2:0]        grp,
  input  logic [N:0]        mcand,
  output logic signed [N+1:0] pp
);

  logic signed [N+1:0] a1;
  logic signed [N+1:0] a2;
  booth_sel_t          sel;

  // The extended multiplicand never reaches -2^N, so -2A always fits in N+2 bits.
  always_comb begin
    a1  = {mcand[N], mcand};
    a2  = {mcand, 1'b0};
    sel = booth_decode(grp);
    pp  = '0;
    case (sel)
      POS1:    pp = a1;
      POS2:    pp = a2;
      NEG1:    pp = -a1;
      NEG2:    pp = -a2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/math_multiplier_booth_radix_4_seq.sv
// Iterative radix-4 Booth multiplier: one Booth group retired per clock.
module math_multiplier_booth_radix_4_seq
  import math_booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic                              i_clk,
  input logic                              i_rst_n,
  math_multiplier_booth_radix_4_seq_if.slave bus
);

  localparam int unsigned G     = booth_groups(N);
  localparam int unsigned OP_W  = N + 1;
  localparam int unsigned M_W   = 2 * G + 1;
  localparam int unsigned ACC_W = 2 * N + 2;
  localparam int unsigned P_W   = 2 * N;
  localparam int unsigned CNT_W = $clog2(G);

  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [M_W-1:0]           mreg_q, mreg_d;
  logic [OP_W-1:0]          mcand_q, mcand_d;
  logic [P_W-1:0]           product_q, product_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;

  logic [OP_W-1:0]          mult_x;
  logic [OP_W-1:0]          mcand_x;
  logic signed [OP_W:0]     m_app;
  logic signed [N+1:0]      pp;
  logic [ACC_W-1:0]         pp_ext;

  // Operand extension: sign or zero extend by mode, then append the Booth LSB.
  assign mult_x  = {bus.i_signed & bus.i_multiplier[N-1], bus.i_multiplier};
  assign mcand_x = {bus.i_signed & bus.i_multiplicand[N-1], bus.i_multiplicand};
  assign m_app   = {mult_x, 1'b0};

  math_booth_r4_pp_gen #(.N(N)) u_pp_gen (
    .grp   (mreg_q[2:0]),
    .mcand (mcand_q),
    .pp    (pp)
  );

  // Multiplier register shifts by two per step, so the active group is always bits [2:0].
  assign pp_ext = ACC_W'(pp) << {cnt_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mreg_d    = mreg_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid && ready_q) begin
          state_d = BUSY;
          acc_d   = '0;
          cnt_d   = '0;
          mreg_d  = M_W'(m_app);
          mcand_d = mcand_x;
        end
      end
      BUSY: begin
        acc_d  = acc_q + pp_ext;
        cnt_d  = cnt_q + CNT_W'(1);
        mreg_d = mreg_q >> 2;
        if (cnt_q == CNT_W'(G - 1)) begin
          state_d   = DONE;
          product_d = acc_d[P_W-1:0];
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      mreg_q    <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mreg_q    <= mreg_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_product = product_q;

endmodule

// File: tb/tb_math_multiplier_booth_radix_4_seq.sv
// Directed and randomised checks of the sequential radix-4 Booth multiplier at N=8.
module tb_math_multiplier_booth_radix_4_seq;

  localparam int unsigned N = 8;
  localparam int unsigned G = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  math_multiplier_booth_radix_4_seq_if #(.N(N)) bus ();

  math_multiplier_booth_radix_4_seq #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    return 16'(sa * sb);
  endfunction

  // One full transaction; stall holds i_ready low for that many cycles after o_valid.
  task automatic run_op(input string tag, input logic sgn, input logic [7:0] mplier,
                        input logic [7:0] mcand, input logic [15:0] exp, input int stall);
    int lat;
    bus.i_signed       = sgn;
    bus.i_multiplier   = mplier;
    bus.i_multiplicand = mcand;
    bus.i_valid        = 1'b1;
    bus.i_ready        = (stall == 0);
    tick();
    bus.i_valid = 1'b0;
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
    lat = 0;
    while (!bus.o_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(G));
    check({tag, "_prod"}, 64'(bus.o_product), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
      check({tag, "_hold_prod"}, 64'(bus.o_product), 64'(exp));
      check({tag, "_hold_ready"}, 64'(bus.o_ready), 64'd0);
    end
    bus.i_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, 64'(bus.o_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          spacing;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;

    n_checks           = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_signed       = 1'b0;
    bus.i_multiplier   = '0;
    bus.i_multiplicand = '0;
    bus.i_ready        = 1'b1;

    repeat (2) tick();
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_prod", 64'(bus.o_product), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 0);
    run_op("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000, 0);
    run_op("s_7f_80", 1'b1, 8'h7F, 8'h80, 16'hC080, 0);
    run_op("s_ff_01", 1'b1, 8'hFF, 8'h01, 16'hFFFF, 0);
    run_op("u_ff_01", 1'b0, 8'hFF, 8'h01, 16'h00FF, 0);
    run_op("s_zero", 1'b1, 8'h00, 8'h85, 16'h0000, 0);
    run_op("u_80_02", 1'b0, 8'h80, 8'h02, 16'h0100, 0);
    run_op("s_80_ff", 1'b1, 8'h80, 8'hFF, 16'h0080, 0);
    run_op("s_fd_07", 1'b1, 8'hFD, 8'h07, 16'hFFEB, 0);

    // Back-pressure: product held for 10 cycles with i_ready low.
    run_op("bp", 1'b1, 8'h80, 8'h80, 16'h4000, 10);

    // i_valid held high across BUSY/DONE with changing operands.
    bus.i_signed       = 1'b1;
    bus.i_multiplier   = 8'h02;
    bus.i_multiplicand = 8'h03;
    bus.i_valid        = 1'b1;
    bus.i_ready        = 1'b1;
    tick();
    bus.i_signed       = 1'b0;
    bus.i_multiplier   = 8'h04;
    bus.i_multiplicand = 8'h05;
    lat = 0;
    while (!bus.o_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("hv_lat1", 64'(lat), 64'(G));
    check("hv_prod1", 64'(bus.o_product), 64'h0006);
    spacing = lat;
    while (!bus.o_ready && spacing < 20) begin
      tick();
      spacing++;
    end
    tick();
    spacing++;
    check("hv_spacing", 64'(spacing), 64'(G + 2));
    check("hv_busy2", 64'(bus.o_busy), 64'd1);
    bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("hv_lat2", 64'(lat), 64'(G));
    check("hv_prod2", 64'(bus.o_product), 64'h0014);
    tick();
    check("hv_valid_drop", 64'(bus.o_valid), 64'd0);

    // Asynchronous reset in the middle of an operation.
    bus.i_signed       = 1'b0;
    bus.i_multiplier   = 8'h55;
    bus.i_multiplicand = 8'h33;
    bus.i_valid        = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    check("mid_rst_ready", 64'(bus.o_ready), 64'd1);
    check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    check("mid_rst_prod", 64'(bus.o_product), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_hold_valid", 64'(bus.o_valid), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_valid", 64'(bus.o_valid), 64'd0);
    end
    run_op("rst_next", 1'b0, 8'h03, 8'h05, 16'h000F, 0);

    for (int i = 0; i < 300; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      b   = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      run_op("rnd", sgn, a, b, ref_mul(sgn, a, b), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
